dac_wave_gen: RTL

Parametrised waveform engine for the I2C DAC path. Generates hold, sawtooth, triangle or square code sequences of configurable width, range, step size and step rate. Drives the transfer-request side of the team's `iic_drive` (two data bytes, no word address), with coalescing of updates while a transfer is in flight, bounded retry on NACK and error counting. Sits between the user/config logic and `iic_drive`.

---
 rtl/dac_wave_gen.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/dac_wave_gen.sv
// Waveform code generator (hold/sawtooth/triangle/square) feeding iic_drive with
// two-byte DAC frames, latest-code coalescing, bounded NACK retry and drop counting.
module dac_wave_gen #(
  parameter int unsigned DAC_WIDTH    = 8,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                 dac_clk,
  input  logic                 dac_rst,
  input  logic                 dac_en,
  input  logic [1:0]           wave_mode,
  input  logic [DAC_WIDTH-1:0] code_min,
  input  logic [DAC_WIDTH-1:0] code_max,
  input  logic [DAC_WIDTH-1:0] hold_code,
  input  logic [DAC_WIDTH-1:0] step_size,
  input  logic [27:0]          step_div,
  input  logic                 iic_ready,
  input  logic                 iic_ack_error,
  output logic                 iic_start,
  output logic [15:0]          iic_wdata,
  output logic [DAC_WIDTH-1:0] dac_code,
  output logic [7:0]           err_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {MODE_HOLD, MODE_SAW, MODE_TRI, MODE_SQR} mode_t;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  localparam logic [15:0] TO_LAST   = 16'(BUSY_TIMEOUT - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

  mode_t                mode;
  logic [1:0]           mode_q;
  logic                 reload_q, reload, tick;
  logic [27:0]          div_cnt, div_last;
  logic [DAC_WIDTH-1:0] step, code_n;
  logic [DAC_WIDTH:0]   sum, floor_up;
  logic                 dir_up, dir_n, sq_high, sq_n;
  logic                 range_bad, out_of_range;

  assign mode         = mode_t'(wave_mode);
  assign reload       = reload_q | (wave_mode != mode_q);
  assign div_last     = (step_div == '0) ? '0 : step_div - 28'd1;
  assign tick         = dac_en & (div_cnt >= div_last);
  assign step         = (step_size == '0) ? DAC_WIDTH'(1) : step_size;
  assign sum          = {1'b0, dac_code} + {1'b0, step};
  assign floor_up     = {1'b0, code_min} + {1'b0, step};
  assign range_bad    = code_min > code_max;
  assign out_of_range = (dac_code < code_min) | (dac_code > code_max);

  always_comb begin
    code_n = dac_code;
    dir_n  = dir_up;
    sq_n   = sq_high;
    if (reload) begin
      code_n = (mode == MODE_HOLD) ? hold_code : code_min;
      dir_n  = 1'b1;
      sq_n   = 1'b0;
    end else if (dac_en) begin
      if (mode == MODE_HOLD) begin
        code_n = hold_code;
      end else if (range_bad) begin
        code_n = code_min;
      end else if (tick) begin
        case (mode)
          MODE_SAW: code_n = (out_of_range || sum > {1'b0, code_max}) ? code_min : sum[DAC_WIDTH-1:0];
          MODE_TRI: begin
            if (dac_code > code_max) begin
              code_n = code_max;
              dir_n  = 1'b0;
            end else if (dac_code < code_min) begin
              code_n = code_min;
              dir_n  = 1'b1;
            end else if (dir_up) begin
              if (sum >= {1'b0, code_max}) begin
                code_n = code_max;
                dir_n  = 1'b0;
              end else begin
                code_n = sum[DAC_WIDTH-1:0];
              end
            end else if ({1'b0, dac_code} < floor_up) begin
              code_n = code_min;
              dir_n  = 1'b1;
            end else begin
              code_n = dac_code - step;
            end
          end
          MODE_SQR: begin
            if (out_of_range) begin
              code_n = code_min;
              sq_n   = 1'b0;
            end else begin
              code_n = sq_high ? code_min : code_max;
              sq_n   = ~sq_high;
            end
          end
          default: code_n = dac_code;
        endcase
      end
    end
  end

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      mode_q   <= wave_mode;
      reload_q <= 1'b1;
      div_cnt  <= '0;
      dac_code <= '0;
      dir_up   <= 1'b1;
      sq_high  <= 1'b0;
    end else begin
      mode_q   <= wave_mode;
      reload_q <= 1'b0;
      dac_code <= code_n;
      dir_up   <= dir_n;
      sq_high  <= sq_n;
      if (reload)      div_cnt <= '0;
      else if (dac_en) div_cnt <= tick ? '0 : div_cnt + 28'd1;
    end
  end

  state_t               state_q, state_n;
  logic [7:0]           retry_q, retry_n, err_n;
  logic [15:0]          to_q, to_n, wdata_n;
  logic                 resend_q, resend_n, nack_q, nack_n, start_n;
  logic                 ack_valid_q, ack_valid_n, pending, fail, done;
  logic [DAC_WIDTH-1:0] snap_q, snap_n, ack_code_q, ack_code_n;
  logic [11:0]          code12;

  assign code12  = 12'(dac_code) << (12 - DAC_WIDTH);
  assign pending = ~ack_valid_q | (dac_code != ack_code_q);
  assign busy    = state_q != IDLE;

  always_comb begin
    state_n     = state_q;
    retry_n     = retry_q;
    resend_n    = resend_q;
    to_n        = to_q;
    nack_n      = nack_q;
    snap_n      = snap_q;
    ack_code_n  = ack_code_q;
    ack_valid_n = ack_valid_q;
    err_n       = err_cnt;
    start_n     = 1'b0;
    wdata_n     = iic_wdata;
    fail        = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        // Hold off while a reload is due so the pre-reload code is never framed.
        if (iic_ready && (resend_q || (dac_en && pending && !reload))) begin
          start_n  = 1'b1;
          state_n  = WAIT_BUSY;
          to_n     = '0;
          nack_n   = 1'b0;
          resend_n = 1'b0;
          if (!resend_q) begin
            snap_n  = dac_code;
            retry_n = '0;
            wdata_n = {4'b0000, code12};
          end
        end
      end
      WAIT_BUSY: begin
        if (!iic_ready)           state_n = WAIT_DONE;
        else if (to_q == TO_LAST) fail    = 1'b1;
        else                      to_n    = to_q + 16'd1;
      end
      WAIT_DONE: begin
        if (iic_ack_error) nack_n = 1'b1;
        if (iic_ready) begin
          if (nack_q || iic_ack_error) fail = 1'b1;
          else                         done = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (done) begin
      state_n     = IDLE;
      ack_code_n  = snap_q;
      ack_valid_n = 1'b1;
    end
    if (fail) begin
      state_n = IDLE;
      if (retry_q < RETRY_MAX) begin
        retry_n  = retry_q + 8'd1;
        resend_n = 1'b1;
      end else begin
        err_n       = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
        ack_code_n  = snap_q;
        ack_valid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      state_q     <= IDLE;
      retry_q     <= '0;
      resend_q    <= 1'b0;
      to_q        <= '0;
      nack_q      <= 1'b0;
      snap_q      <= '0;
      ack_code_q  <= '0;
      ack_valid_q <= 1'b0;
      err_cnt     <= '0;
      iic_start   <= 1'b0;
      iic_wdata   <= '0;
    end else begin
      state_q     <= state_n;
      retry_q     <= retry_n;
      resend_q    <= resend_n;
      to_q        <= to_n;
      nack_q      <= nack_n;
      snap_q      <= snap_n;
      ack_code_q  <= ack_code_n;
      ack_valid_q <= ack_valid_n;
      err_cnt     <= err_n;
      iic_start   <= start_n;
      iic_wdata   <= wdata_n;
    end
  end

endmodule
